adder_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one 16-bit ripple adder datapath (FullAdder16Bit) among N requesters. Each granted request performs a 16-bit add or subtract. A per-requester saved carry lets a requester build wider operations as multiple chained 16-bit beats. The result is held in a single registered response slot with a valid/ready handshake. The block sits between ALU front-end clients and the shared adder; it is the only instantiation point of FullAdder16Bit in the datapath.

---
 rtl/adder_share_arbiter_if.sv | 30 +++
 rtl/adder_share_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between ALU front-end clients and the shared adder arbiter.
// Requesters drive the request side and the response consumer drives rsp_ready.
interface adder_share_arbiter_if #(
   parameter int N = 4
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [16*N-1:0]   req_a;
   logic [16*N-1:0]   req_b;
   logic [N-1:0]      req_sub;
   logic [N-1:0]      req_chain;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [15:0]       rsp_sum;
   logic              rsp_cout;
   logic              rsp_ovf;

   modport master (
      output req_valid, req_a, req_b, req_sub, req_chain, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, req_chain, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
   );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 16-bit ripple adder among N requesters, with per-requester
// saved carry for multi-beat wide operations and a single registered response slot.
module FullAdder16Bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic carry;

   // Carry kept as a loop variable so the chain is a single combinational block.
   always_comb begin
      carry = cin;
      sum   = '0;
      for (int i = 0; i < 16; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end
endmodule

module adder_share_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_share_arbiter_if.slave rif
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] ptr_next;
   logic [N-1:0]  carry_reg;
   logic          rsp_valid_reg;
   logic [IW-1:0] rsp_id_reg;
   logic [15:0]   rsp_sum_reg;
   logic          rsp_cout_reg;
   logic          rsp_ovf_reg;

   logic          slot_free;
   logic          gnt_found;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] cand;
   logic [N-1:0]  ready_c;

   logic [15:0]   a_arr [N];
   logic [15:0]   b_arr [N];
   logic [15:0]   a_sel;
   logic [15:0]   bx_sel;
   logic          cin_sel;
   logic [15:0]   sum_c;
   logic          cout_c;
   logic          ovf_c;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign a_arr[gi] = rif.req_a[16*gi +: 16];
         assign b_arr[gi] = rif.req_b[16*gi +: 16];
      end
   endgenerate

   assign slot_free = !rsp_valid_reg || rif.rsp_ready;

   // Grant depends only on valids, pointer and slot state; operands never reach req_ready.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      ready_c   = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr_reg) + k) % N);
         if (!gnt_found && slot_free && rif.req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
      if (gnt_found) begin
         ready_c[gnt_idx] = 1'b1;
      end
   end

   assign ptr_next      = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
   assign rif.req_ready = ready_c;

   assign a_sel   = a_arr[gnt_idx];
   assign bx_sel  = rif.req_sub[gnt_idx] ? ~b_arr[gnt_idx] : b_arr[gnt_idx];
   assign cin_sel = rif.req_chain[gnt_idx] ? carry_reg[gnt_idx] : rif.req_sub[gnt_idx];

   FullAdder16Bit u_adder (
      .a    (a_sel),
      .b    (bx_sel),
      .cin  (cin_sel),
      .sum  (sum_c),
      .cout (cout_c)
   );

   assign ovf_c = (a_sel[15] == bx_sel[15]) && (sum_c[15] != a_sel[15]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg       <= '0;
         carry_reg     <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_sum_reg   <= '0;
         rsp_cout_reg  <= 1'b0;
         rsp_ovf_reg   <= 1'b0;
      end else if (gnt_found) begin
         ptr_reg            <= ptr_next;
         carry_reg[gnt_idx] <= cout_c;
         rsp_valid_reg      <= 1'b1;
         rsp_id_reg         <= gnt_idx;
         rsp_sum_reg        <= sum_c;
         rsp_cout_reg       <= cout_c;
         rsp_ovf_reg        <= ovf_c;
      end else if (rif.rsp_ready) begin
         rsp_valid_reg <= 1'b0;
      end
   end

   assign rif.rsp_valid = rsp_valid_reg;
   assign rif.rsp_id    = rsp_id_reg;
   assign rif.rsp_sum   = rsp_sum_reg;
   assign rif.rsp_cout  = rsp_cout_reg;
   assign rif.rsp_ovf   = rsp_ovf_reg;
endmodule
